// File: rtl/fetch_decode_if.sv
// ----------------------------------------------------------------------------
// fetch_decode_if
// Bundles the fetch/decode front-end outputs that drive the RF/ALU/CY/A
// datapath.
//   PC_Addr  [4:0]  current program counter / ROM address
//   Ins      [5:0]  instruction at PC_Addr
//   RegAddr  [3:0]  register-file address
//   ALUCode  [2:0]  ALU operation select
//   Reg_CE          register-file write enable
//   A_CE            accumulator load enable
//   CY_CE           carry flag load enable
//   nResetCY        active-low carry clear request
// Modports: master (front end, drives everything), slave (datapath, reads).
// ----------------------------------------------------------------------------
interface fetch_decode_if;
    logic [4:0] PC_Addr;
    logic [5:0] Ins;
    logic [3:0] RegAddr;
    logic [2:0] ALUCode;
    logic       Reg_CE;
    logic       A_CE;
    logic       CY_CE;
    logic       nResetCY;

    modport master (
        output PC_Addr, Ins, RegAddr, ALUCode, Reg_CE, A_CE, CY_CE, nResetCY
    );

    modport slave (
        input PC_Addr, Ins, RegAddr, ALUCode, Reg_CE, A_CE, CY_CE, nResetCY
    );
endinterface

// File: rtl/fetch_decode_unit.sv
// ----------------------------------------------------------------------------
// fetch_decode_unit
// Front end of the 8-instruction-class micro-CPU: a 5-bit program counter,
// a 32x6-bit asynchronous-read program ROM and a combinational decoder that
// produces the datapath controls for the current instruction.
// Ports:
//   clk     in   rising-edge system clock
//   Reset   in   asynchronous, active-high reset
//   o_bus   fetch_decode_if.master  (PC_Addr, Ins, RegAddr, ALUCode,
//                                    Reg_CE, A_CE, CY_CE, nResetCY)
// Configuration:
//   FDU_HALT_EN  when defined, HALT (110111) freezes the PC until Reset;
//                when undefined, HALT decodes as a NOP.
// ----------------------------------------------------------------------------
module fetch_decode_unit (
    input  logic          clk,
    input  logic          Reset,
    fetch_decode_if.master o_bus
);

    logic [4:0] r_pc;
    logic [4:0] w_pc_next;
    logic [5:0] w_ins;
    logic [3:0] w_reg_addr;
    logic [2:0] w_alu_code;
    logic       w_reg_ce;
    logic       w_a_ce;
    logic       w_cy_ce;
    logic       w_nreset_cy;
    logic       w_halt;

    // Program counter; natural 5-bit overflow gives the 31 -> 0 wrap.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            r_pc <= 5'd0;
        end else begin
            r_pc <= w_pc_next;
        end
    end

    assign w_pc_next = w_halt ? r_pc : r_pc + 5'd1;

    // Program ROM, asynchronous read.
    always_comb begin
        w_ins = 6'b110000;
        unique case (r_pc)
            5'd0:    w_ins = 6'b110001;  // CLRC
            5'd1:    w_ins = 6'b000001;  // LD  A,R1
            5'd2:    w_ins = 6'b100010;  // ADD A,R2
            5'd3:    w_ins = 6'b010011;  // ST  R3
            default: w_ins = 6'b110000;  // NOP
        endcase
    end

    // Decoder. RegAddr carries the operand field for every class except the
    // ALU A,R0 group, which always addresses R0.
    always_comb begin
        w_reg_addr  = w_ins[3:0];
        w_alu_code  = 3'b000;
        w_reg_ce    = 1'b0;
        w_a_ce      = 1'b0;
        w_cy_ce     = 1'b0;
        w_nreset_cy = 1'b1;
        w_halt      = 1'b0;

        unique case (w_ins[5:4])
            2'b00: begin
                w_a_ce = 1'b1;
            end
            2'b01: begin
                w_reg_ce = 1'b1;
            end
            2'b10: begin
                w_alu_code = 3'b001;
                w_a_ce     = 1'b1;
                w_cy_ce    = 1'b1;
            end
            2'b11: begin
                if (w_ins[3]) begin
                    w_reg_addr = 4'd0;
                    w_alu_code = w_ins[2:0];
                    w_a_ce     = 1'b1;
                    w_cy_ce    = 1'b1;
                end else if (w_ins[3:0] == 4'b0001) begin
                    w_nreset_cy = 1'b0;
                end else if (w_ins[3:0] == 4'b0111) begin
`ifdef FDU_HALT_EN
                    w_halt = 1'b1;
`else
                    w_halt = 1'b0;
`endif
                end
            end
            default: begin
                w_reg_addr = w_ins[3:0];
            end
        endcase

        // Reset masks the enables only; address and ALU code keep decoding.
        if (Reset) begin
            w_reg_ce    = 1'b0;
            w_a_ce      = 1'b0;
            w_cy_ce     = 1'b0;
            w_nreset_cy = 1'b1;
        end
    end

    assign o_bus.PC_Addr  = r_pc;
    assign o_bus.Ins      = w_ins;
    assign o_bus.RegAddr  = w_reg_addr;
    assign o_bus.ALUCode  = w_alu_code;
    assign o_bus.Reg_CE   = w_reg_ce;
    assign o_bus.A_CE     = w_a_ce;
    assign o_bus.CY_CE    = w_cy_ce;
    assign o_bus.nResetCY = w_nreset_cy;

endmodule

// File: tb/tb_fetch_decode_unit.sv
// ----------------------------------------------------------------------------
// tb_fetch_decode_unit
// Directed bench for fetch_decode_unit: reset state, program walk, wrap,
// asynchronous mid-run reset, decode of overlaid instructions and HALT.
// Honours FDU_HALT_EN for the HALT expectation.
// ----------------------------------------------------------------------------
module tb_fetch_decode_unit;

    logic clk;
    logic Reset;
    int   n_vec;
    int   n_err;

    fetch_decode_if bus ();

    fetch_decode_unit dut (
        .clk   (clk),
        .Reset (Reset),
        .o_bus (bus)
    );

`ifdef FDU_HALT_EN
    localparam logic [4:0] HaltPcExp = 5'd4;
`else
    localparam logic [4:0] HaltPcExp = 5'd14;
`endif

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One full clock period; outputs are sampled well after the rising edge.
    task automatic tick();
        #5 clk = 1'b1;
        #5 clk = 1'b0;
    endtask

    task automatic enables(input string tag, input logic reg_ce, input logic a_ce,
                           input logic cy_ce, input logic nres);
        chk({tag, ".Reg_CE"},   {7'd0, bus.Reg_CE},   {7'd0, reg_ce});
        chk({tag, ".A_CE"},     {7'd0, bus.A_CE},     {7'd0, a_ce});
        chk({tag, ".CY_CE"},    {7'd0, bus.CY_CE},    {7'd0, cy_ce});
        chk({tag, ".nResetCY"}, {7'd0, bus.nResetCY}, {7'd0, nres});
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        clk   = 1'b0;
        Reset = 1'b0;

        // Reset with clock idle.
        #1 Reset = 1'b1;
        #1;
        chk("rst.PC",      {3'd0, bus.PC_Addr}, 8'd0);
        chk("rst.Ins",     {2'd0, bus.Ins},     8'b00110001);
        chk("rst.RegAddr", {4'd0, bus.RegAddr}, 8'd1);
        chk("rst.ALUCode", {5'd0, bus.ALUCode}, 8'd0);
        enables("rst", 1'b0, 1'b0, 1'b0, 1'b1);

        Reset = 1'b0;
        #1;
        chk("a0.PC", {3'd0, bus.PC_Addr}, 8'd0);
        enables("a0", 1'b0, 1'b0, 1'b0, 1'b0);

        // Program walk.
        tick();
        chk("a1.PC",      {3'd0, bus.PC_Addr}, 8'd1);
        chk("a1.RegAddr", {4'd0, bus.RegAddr}, 8'd1);
        chk("a1.ALUCode", {5'd0, bus.ALUCode}, 8'd0);
        enables("a1", 1'b0, 1'b1, 1'b0, 1'b1);
        tick();
        chk("a2.PC",      {3'd0, bus.PC_Addr}, 8'd2);
        chk("a2.RegAddr", {4'd0, bus.RegAddr}, 8'd2);
        chk("a2.ALUCode", {5'd0, bus.ALUCode}, 8'd1);
        enables("a2", 1'b0, 1'b1, 1'b1, 1'b1);
        tick();
        chk("a3.PC",      {3'd0, bus.PC_Addr}, 8'd3);
        chk("a3.RegAddr", {4'd0, bus.RegAddr}, 8'd3);
        enables("a3", 1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        chk("a4.PC",  {3'd0, bus.PC_Addr}, 8'd4);
        chk("a4.Ins", {2'd0, bus.Ins},     8'b00110000);
        enables("a4", 1'b0, 1'b0, 1'b0, 1'b1);

        // Asynchronous reset between edges at address 5.
        tick();
        chk("a5.PC", {3'd0, bus.PC_Addr}, 8'd5);
        #2 Reset = 1'b1;
        #1;
        chk("mid_rst.PC", {3'd0, bus.PC_Addr}, 8'd0);
        enables("mid_rst", 1'b0, 1'b0, 1'b0, 1'b1);
        Reset = 1'b0;
        tick();
        chk("mid_rel.PC", {3'd0, bus.PC_Addr}, 8'd1);

        // Wrap-around: 32 edges from release returns to 0.
        Reset = 1'b1;
        #1 Reset = 1'b0;
        for (int i = 0; i < 31; i++) tick();
        chk("w31.PC",  {3'd0, bus.PC_Addr}, 8'd31);
        chk("w31.Ins", {2'd0, bus.Ins},     8'b00110000);
        tick();
        chk("w32.PC",  {3'd0, bus.PC_Addr}, 8'd0);
        chk("w32.Ins", {2'd0, bus.Ins},     8'b00110001);

        // Decode of overlaid instructions.
        force dut.w_ins = 6'b111101;
        #1;
        chk("alu.RegAddr", {4'd0, bus.RegAddr}, 8'd0);
        chk("alu.ALUCode", {5'd0, bus.ALUCode}, 8'd5);
        enables("alu", 1'b0, 1'b1, 1'b1, 1'b1);
        force dut.w_ins = 6'b110101;
        #1;
        enables("nop", 1'b0, 1'b0, 1'b0, 1'b1);
        release dut.w_ins;
        #1;

        // HALT at address 4.
        Reset = 1'b1;
        #1 Reset = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("h0.PC", {3'd0, bus.PC_Addr}, 8'd4);
        force dut.w_ins = 6'b110111;
        #1;
        for (int i = 0; i < 10; i++) tick();
        chk("halt.PC", {3'd0, bus.PC_Addr}, {3'd0, HaltPcExp});
        enables("halt", 1'b0, 1'b0, 1'b0, 1'b1);
        release dut.w_ins;
        Reset = 1'b1;
        #1;
        chk("halt_rst.PC", {3'd0, bus.PC_Addr}, 8'd0);
        Reset = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_decode_unit.md
# fetch_decode_unit

Front end of the 8-instruction-class micro-CPU. It holds a 5-bit program counter and a 32×6-bit program ROM, and it decodes the current instruction combinationally into datapath controls. Those controls are register address, ALU code, register/accumulator/carry enables and carry clear, and they drive the RF/ALU/CY/A datapath directly.

## Interface
- No parameters; widths fixed (address 5 b, instruction 6 b).
- Clocking: one clock; reset is asynchronous and active-high.
- clk  in  1  rising-edge system clock
- Reset  in  1  asynchronous, active-high reset
- PC_Addr  out  5  current program counter / ROM address
- Ins  out  6  instruction at PC_Addr
- RegAddr  out  4  register-file address
- ALUCode  out  3  ALU operation select
- Reg_CE  out  1  register-file write enable
- A_CE  out  1  accumulator load enable
- CY_CE  out  1  carry flag load enable
- nResetCY  out  1  active-low synchronous carry clear request

## Operation
- PC: 5-bit up-counter, +1 per clk; wraps 31 -> 0.
- ROM: asynchronous read, Ins = ROM[PC_Addr]. Default contents:
  - 0: 110001 (CLRC)
  - 1: 000001 (LD A,R1)
  - 2: 100010 (ADD A,R2)
  - 3: 010011 (ST R3)
  - 4–31: 110000 (NOP)
- Decode: Ins[5:4] is the class and Ins[3:0] is the operand n. Unlisted outputs are 0, except nResetCY, which is 1.
  - 00 LD A,Rn: RegAddr=n, ALUCode=000, A_CE=1.
  - 01 ST Rn,A: RegAddr=n, Reg_CE=1.
  - 10 ADD A,Rn: RegAddr=n, ALUCode=001, A_CE=1, CY_CE=1.
  - 11 with Ins[3]=1 (ALU A,R0): RegAddr=0, ALUCode=Ins[2:0], A_CE=1, CY_CE=1.
  - 11 with Ins[3:0]=0001 (CLRC): nResetCY=0.
  - 11 with Ins[3:0]=0111 (HALT): see Configuration. In builds without the macro, HALT decodes as NOP.
  - 11 with any other Ins[3:0] (NOP): no enables.
- While Reset=1, all enables are forced inactive: Reg_CE=A_CE=CY_CE=0, nResetCY=1. RegAddr and ALUCode still follow the decode.

## Timing
- Reset asserted: PC_Addr=0 immediately, independent of clk.
- Reset outputs: Ins=110001, RegAddr=0001, ALUCode=000, enables inactive.
- First rising clk edge after Reset deasserts: PC_Addr becomes 1.
- Decode latency: zero cycles. All decode outputs are combinational from PC_Addr, valid one comb delay after each edge.
- The instruction at address k is presented for exactly one cycle, and the datapath consumes it on the next edge.
- Reset asserted mid-run: PC returns to 0 asynchronously. The count resumes from 0 on the first edge after release.
- Wrap-around: after address 31 the next edge gives 0, with no stall and no flag.

## Configuration
- Macro FDU_HALT_EN.
- When defined: the HALT instruction (110111) at PC_Addr holds the PC (no increment) until Reset. HALT outputs no enables.
- When undefined: 110111 is a NOP and the PC keeps counting.
- The default ROM image contains no HALT in either build.

## Test plan
- Reset: assert Reset with clk idle -> PC_Addr=0, Ins=110001, Reg_CE=A_CE=CY_CE=0, nResetCY=1. Release -> nResetCY=0 at addr 0.
- Program walk: release reset, 4 edges -> sequence (addr, outputs):
  - 0: nResetCY=0
  - 1: RegAddr=1, A_CE=1, ALUCode=000
  - 2: RegAddr=2, ALUCode=001, A_CE=CY_CE=1
  - 3: RegAddr=3, Reg_CE=1
  - 4: NOP
- Wrap: run 32 edges from reset release -> PC_Addr returns to 0 and Ins=110001 again.
- Async reset mid-run: assert Reset between edges at addr 5 -> PC_Addr=0 before the next edge. First edge after release -> 1.
- Decode sweep: force or overlay ROM with 111101 -> RegAddr=0, ALUCode=101, A_CE=CY_CE=1. With 110101 -> all enables 0, nResetCY=1.
- FDU_HALT_EN: place 110111 at addr 4. Defined -> PC holds at 4 for 10 edges. Undefined -> PC reaches 14.
